// File: rtl/muldiv_pkg.sv
// Shared definitions for the MULT/DIV sequencer: ALU control codes, FSM
// encoding and the operation kind carried through a multi-cycle request.
package muldiv_pkg;

    localparam logic [3:0] OP_MULT = 4'b1111;
    localparam logic [3:0] OP_DIV  = 4'b1110;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_RUN   = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef enum logic {
        K_MULT = 1'b0,
        K_DIV  = 1'b1
    } op_kind_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between the EX stage (master) and the MULT/DIV
// sequencer (slave); HI/LO results travel back on the same interface.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, alu_ctrl, op_a, op_b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, alu_ctrl, op_a, op_b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_datapath.sv
// Combinational single-step engine: one shift-add multiply bit or one
// restoring-divide bit per evaluation, on unsigned magnitudes.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    input  op_kind_t           i_op,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_new;
    logic [2*WIDTH-1:0] w_div_next;

    // MULT: acc = {partial_hi, multiplier}; the carry out of the add shifts into the top bit.
    assign w_sum      = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    assign w_mul_next = {w_sum, i_acc[WIDTH-1:1]};

    // DIV: acc = {rem, quot}; the shifted remainder is kept W+1 bits so no bit is lost.
    assign w_rem_sh   = i_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge       = (w_rem_sh >= {1'b0, i_operand});
    assign w_rem_new  = w_ge ? WIDTH'(w_rem_sh - {1'b0, i_operand}) : w_rem_sh[WIDTH-1:0];
    assign w_div_next = {w_rem_new, i_acc[WIDTH-2:0], w_ge};

    assign o_acc = (i_op == K_DIV) ? w_div_next : w_mul_next;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed MULT/DIV sequencer owning the architectural HI/LO
// registers; holds busy so the pipeline stalls while an operation runs.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    muldiv_sequencer_if.slave  bus
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next;
    op_kind_t           r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_operand;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_neg_lo;
    logic               r_neg_rem;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_div0;
    logic               w_busy;
    logic               w_done;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_accept = (r_state == S_IDLE) && bus.start &&
                      ((bus.alu_ctrl == OP_MULT) || (bus.alu_ctrl == OP_DIV));
    assign w_div0   = (r_op == K_DIV) && (r_b == '0);

    // Negating as an unsigned W-bit value maps 0x80000000 onto itself, its true magnitude.
    assign w_mag_a  = r_a[WIDTH-1] ? -r_a : r_a;
    assign w_mag_b  = r_b[WIDTH-1] ? -r_b : r_b;

    assign w_prod   = r_neg_lo  ? -r_acc              : r_acc;
    assign w_quot   = r_neg_lo  ? -r_acc[WIDTH-1:0]   : r_acc[WIDTH-1:0];
    assign w_rem    = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .i_op      (r_op),
        .o_acc     (w_acc_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        w_next = r_state;
        w_busy = 1'b1;
        w_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_accept) w_next = S_PREP;
            end
            S_PREP:  w_next = w_div0 ? S_DONE : S_RUN;
            S_RUN:   if (r_cnt == LAST) w_next = S_FIXUP;
            S_FIXUP: w_next = S_DONE;
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= K_MULT;
            r_a       <= '0;
            r_b       <= '0;
            r_operand <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg_lo  <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dbz     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: if (w_accept) begin
                    r_a   <= bus.op_a;
                    r_b   <= bus.op_b;
                    r_op  <= (bus.alu_ctrl == OP_DIV) ? K_DIV : K_MULT;
                    r_dbz <= 1'b0;
                end
                S_PREP: begin
                    r_neg_lo  <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
                    r_neg_rem <= r_a[WIDTH-1];
                    r_cnt     <= '0;
                    if (r_op == K_DIV) begin
                        r_acc     <= {{WIDTH{1'b0}}, w_mag_a};
                        r_operand <= w_mag_b;
                    end else begin
                        r_acc     <= {{WIDTH{1'b0}}, w_mag_b};
                        r_operand <= w_mag_a;
                    end
                    if (w_div0) begin
                        r_dbz <= 1'b1;
                        r_lo  <= '1;
                        r_hi  <= r_a;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIXUP: begin
                    if (r_op == K_DIV) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: the driver pushes hand-computed results
// into a scoreboard queue, a monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
        int           acc_cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("hi",          bus.hi, e.hi);
                check("lo",          bus.lo, e.lo);
                check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
                check("latency",     32'(cyc - e.acc_cyc), 32'(e.lat));
                check("busy_in_done", {31'd0, bus.busy}, 32'd1);
            end
        end
    end

    task automatic issue(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit expect_it, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input logic edbz, input int elat);
        exp_t e;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.alu_ctrl = ctrl;
        bus.op_a     = a;
        bus.op_b     = b;
        if (expect_it) begin
            e.hi = ehi; e.lo = elo; e.dbz = edbz; e.lat = elat; e.acc_cyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("idle_after_done", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        bus.start = 1'b0; bus.alu_ctrl = 4'h0; bus.op_a = '0; bus.op_b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_dbz",  {31'd0, bus.div_by_zero}, 32'd0);
        check("rst_hi",   bus.hi, 32'd0);
        check("rst_lo",   bus.lo, 32'd0);
        rst_n = 1'b1;

        // 7 x -3 = -21
        issue(OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
        drain(60);
        // most-negative squared
        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 32'h0000_0000, 1'b0, 34);
        drain(60);
        // -7 / 2 = -3 rem -1
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
        drain(60);
        // 5 / 0
        issue(OP_DIV, 32'h0000_0005, 32'h0000_0000, 1, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1);
        drain(60);
        // dbz clears on next accept: -100 / 7 = -14 rem -2
        issue(OP_DIV, 32'hFFFF_FF9C, 32'h0000_0007, 1, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 34);
        drain(60);
        // 0x80000000 / -1 = 0x80000000 rem 0
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 32'h8000_0000, 1'b0, 34);
        drain(60);
        // -1 x -1 = 1
        issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0000, 32'h0000_0001, 1'b0, 34);
        drain(60);

        // Unsupported control code is ignored
        issue(4'b0010, 32'h0000_0011, 32'h0000_0022, 0, '0, '0, 1'b0, 0);
        check("bad_ctrl_busy", {31'd0, bus.busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("bad_ctrl_busy_later", {31'd0, bus.busy}, 32'd0);
        check("bad_ctrl_hi", bus.hi, 32'h0000_0000);
        check("bad_ctrl_lo", bus.lo, 32'h0000_0001);

        // Second start while busy is ignored; hi/lo hold the previous result
        issue(OP_MULT, 32'h0000_1234, 32'h0000_0100, 1, 32'h0000_0000, 32'h0012_3400, 1'b0, 34);
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.alu_ctrl = OP_DIV; bus.op_a = 32'd9; bus.op_b = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_during_run", {31'd0, bus.busy}, 32'd1);
        check("hold_hi_busy", bus.hi, 32'h0000_0000);
        check("hold_lo_busy", bus.lo, 32'h0000_0001);
        drain(60);
        repeat (40) @(negedge clk);
        check("no_extra_op", {31'd0, bus.busy}, 32'd0);

        // Reset mid-RUN aborts without a done pulse
        issue(OP_MULT, 32'h0000_0003, 32'h0000_0005, 0, '0, '0, 1'b0, 0);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_hi",   bus.hi, 32'h0000_0000);
        check("abort_lo",   bus.lo, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        // 100 / -7 = -14 rem 2
        issue(OP_DIV, 32'd100, 32'hFFFF_FFF9, 1, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 34);
        drain(60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
